// File: rtl/stream_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_pkg
// Description : Shared types and constants for the packet-aware 1-to-N
//               stream demultiplexer (FSM state encoding, slot limit).
// Revision    : 1.0 - initial release
// ============================================================================
package stream_demux_pkg;

    // Upper bound on the number of output channels the demux supports.
    localparam int MAX_OUT = 16;

    // Lower bound on the number of output channels.
    localparam int MIN_OUT = 2;

    // Packet-tracking state of the input side.
    //   IDLE   : between packets, next accepted beat starts a packet
    //   LOCKED : mid-packet, beats follow the captured select
    //   DROP   : mid-packet with an out-of-range select, beats are discarded
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        DROP   = 2'd2
    } demux_state_e;

endpackage : stream_demux_pkg
`default_nettype wire

// File: rtl/demux_out_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_out_slot
// Description : One-entry output register (valid/data/last) for a single
//               demux channel. Loads on an accepted input beat, clears on a
//               downstream handshake, and reports whether it can take a beat
//               in the current cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_out_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             slot_ready
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             last_q;
    logic             last_d;

    // Next slot contents: a load always wins, so a simultaneous load and
    // unload keeps the slot full and sustains one beat per cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
        end
    end

    // Slot register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    // The slot accepts a new beat if empty or if its content leaves this cycle.
    always_comb begin
        slot_ready = !valid_q || out_ready;
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;

endmodule : demux_out_slot
`default_nettype wire

// File: rtl/stream_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module      : stream_demux_1xn
// Description : Registered, packet-aware 1-to-N stream demultiplexer. The
//               select is captured on the first beat of a packet and held
//               until the last beat; each channel has a one-entry output
//               slot giving one cycle of latency with full backpressure.
//               Packets with an out-of-range select are consumed, flagged
//               and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_demux_1xn
    import stream_demux_pkg::*;
#(
    parameter int N_OUT = 4,
    parameter int WIDTH = 8,
    parameter int SEL_W = $clog2(N_OUT),
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_last,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_last,
    output logic                   err_sel,
    output logic [CNT_W-1:0]       drop_cnt
);

    // Channel count widened by one bit so it can be compared against any
    // select value, including the all-ones value when N_OUT is a power of 2.
    localparam logic [SEL_W:0]   c_N_OUT_EXT = N_OUT[SEL_W:0];
    localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

    demux_state_e     state_q;
    demux_state_e     state_d;
    logic [SEL_W-1:0] cur_sel_q;
    logic [SEL_W-1:0] cur_sel_d;
    logic             err_sel_q;
    logic             err_sel_d;
    logic [CNT_W-1:0] drop_cnt_q;
    logic [CNT_W-1:0] drop_cnt_d;

    logic             w_sel_ok;
    logic [SEL_W-1:0] w_target;
    logic             w_discard;
    logic             w_target_ready;
    logic             w_accept;
    logic [N_OUT-1:0] w_load;
    logic [N_OUT-1:0] w_slot_ready;

    // Resolve the target channel and whether the current beat is thrown away.
    // In IDLE the live select decides; afterwards the captured one does.
    always_comb begin
        w_sel_ok  = ({1'b0, in_sel} < c_N_OUT_EXT);
        w_target  = (state_q == LOCKED) ? cur_sel_q : in_sel;
        w_discard = (state_q == DROP) || ((state_q == IDLE) && !w_sel_ok);
    end

    // Ready mux: follow the target slot, or always accept when discarding.
    // The loop compare avoids indexing past N_OUT with an unused select code.
    always_comb begin
        w_target_ready = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (w_target == k[SEL_W-1:0]) begin
                w_target_ready = w_slot_ready[k];
            end
        end
        in_ready = w_discard ? 1'b1 : w_target_ready;
    end

    // Input handshake.
    always_comb begin
        w_accept = in_valid && in_ready;
    end

    // One-hot slot load: only the target channel sees an accepted beat.
    always_comb begin
        w_load = '0;
        for (int k = 0; k < N_OUT; k++) begin
            w_load[k] = w_accept && !w_discard && (w_target == k[SEL_W-1:0]);
        end
    end

    // Packet FSM, select capture, error pulse and saturating drop counter.
    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        err_sel_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (w_accept) begin
                    if (w_sel_ok) begin
                        cur_sel_d = in_sel;
                        state_d   = in_last ? IDLE : LOCKED;
                    end else begin
                        err_sel_d = 1'b1;
                        if (drop_cnt_q != c_CNT_MAX) begin
                            drop_cnt_d = drop_cnt_q + 1'b1;
                        end
                        state_d = in_last ? IDLE : DROP;
                    end
                end
            end
            LOCKED, DROP: begin
                if (w_accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any packet in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cur_sel_q  <= '0;
            err_sel_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_sel_q  <= cur_sel_d;
            err_sel_q  <= err_sel_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign err_sel  = err_sel_q;
    assign drop_cnt = drop_cnt_q;

    // One output slot per channel; channels drain independently.
    genvar k;
    generate
        for (k = 0; (k < N_OUT) && (k < MAX_OUT); k++) begin : g_slot
            demux_out_slot #(
                .WIDTH (WIDTH)
            ) u_slot (
                .clk        (clk),
                .rst_n      (rst_n),
                .load       (w_load[k]),
                .load_data  (in_data),
                .load_last  (in_last),
                .out_ready  (out_ready[k]),
                .out_valid  (out_valid[k]),
                .out_data   (out_data[k*WIDTH +: WIDTH]),
                .out_last   (out_last[k]),
                .slot_ready (w_slot_ready[k])
            );
        end
    endgenerate

endmodule : stream_demux_1xn
`default_nettype wire

// File: tb/tb_stream_demux_1xn.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_stream_demux_1xn
// Description : Scoreboard bench for stream_demux_1xn with five channels
//               (non power of two, so out-of-range selects exist) and a
//               3-bit drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_demux_1xn;

    localparam int N_OUT   = 5;
    localparam int WIDTH   = 8;
    localparam int CNT_W   = 3;
    localparam int SEL_W   = $clog2(N_OUT);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_last;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_last;
    logic                   err_sel;
    logic [CNT_W-1:0]       drop_cnt;

    stream_demux_1xn #(
        .N_OUT (N_OUT),
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err_sel   (err_sel),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel expected beats {last, data}, packet
    // tracking, count of dropped packets and the expected error pulse.
    logic [WIDTH:0]   exp_q [N_OUT][$];
    bit               in_pkt;
    int               pkt_dest;
    int               drops;
    bit               exp_err;
    int               n_cmp;
    int               n_err;

    // Downstream ready control.
    bit               rdy_rand;
    logic [N_OUT-1:0] hold_mask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_drops(input int d);
        return (d > CNT_MAX) ? CNT_MAX : d;
    endfunction

    // Expected input readiness from the model: discarded packets are always
    // accepted, routed ones need an empty or draining destination.
    function automatic bit exp_in_ready();
        int d;
        if (in_pkt) d = pkt_dest;
        else        d = (int'(in_sel) < N_OUT) ? int'(in_sel) : -1;
        if (d < 0) return 1'b1;
        return (exp_q[d].size() == 0) || (out_ready[d] == 1'b1);
    endfunction

    // Monitor: compare DUT outputs with the model away from the clock edge and
    // retire beats that complete a downstream handshake.
    always @(negedge clk) begin : monitor
        logic [N_OUT-1:0] ev;
        logic [WIDTH:0]   e;
        if (rst_n) begin
            for (int k = 0; k < N_OUT; k++) ev[k] = (exp_q[k].size() != 0);
            check("out_valid", 64'(out_valid), 64'(ev));
            check("in_ready", 64'(in_ready), 64'(exp_in_ready()));
            check("err_sel", 64'(err_sel), 64'(exp_err));
            exp_err = 1'b0;
            check("drop_cnt", 64'(drop_cnt), 64'(sat_drops(drops)));
            for (int k = 0; k < N_OUT; k++) begin
                if (out_valid[k] && exp_q[k].size() != 0) begin
                    e = exp_q[k][0];
                    check("out_data", 64'(out_data[k*WIDTH +: WIDTH]), 64'(e[WIDTH-1:0]));
                    check("out_last", 64'(out_last[k]), 64'(e[WIDTH]));
                    if (out_ready[k]) void'(exp_q[k].pop_front());
                end
            end
        end
    end

    // Downstream ready driver.
    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = N_OUT'($urandom) & ~hold_mask;
            else          out_ready = {N_OUT{1'b1}} & ~hold_mask;
        end
    end

    // Present one beat until accepted; on acceptance push the expected result.
    task automatic send_beat(input int sel, input logic [WIDTH-1:0] data,
                             input bit last, output int waited);
        bit acc;
        acc    = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_sel   = sel[SEL_W-1:0];
        in_data  = data;
        in_last  = last;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            waited++;
            if (acc) begin
                if (!in_pkt) begin
                    pkt_dest = (sel < N_OUT) ? sel : -1;
                    if (pkt_dest < 0) begin
                        drops++;
                        exp_err = 1'b1;
                    end
                end
                if (pkt_dest >= 0) exp_q[pkt_dest].push_back({last, data});
                in_pkt = !last;
            end
        end
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: beat for sel %0d not accepted in 200 cycles", sel);
        end
    endtask

    // Packet: first beat carries the real select, later beats a random one.
    task automatic send_packet(input int sel, input int len, input bit gaps, output int cycles);
        int w;
        int s;
        cycles = 0;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            s = (i == 0) ? sel : int'($urandom_range(0, 7));
            send_beat(s, WIDTH'($urandom), (i == len - 1), w);
            cycles += w;
        end
    endtask

    task automatic drain();
        int  n;
        bit  busy;
        bit  save;
        save      = rdy_rand;
        rdy_rand  = 1'b0;
        hold_mask = '0;
        n = 0;
        busy = 1'b1;
        while (busy && n < 50) begin
            busy = 1'b0;
            for (int k = 0; k < N_OUT; k++) if (exp_q[k].size() != 0) busy = 1'b1;
            if (busy) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: outputs not drained in 50 cycles");
        end
        rdy_rand = save;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_OUT; k++) exp_q[k].delete();
        in_pkt   = 1'b0;
        pkt_dest = 0;
        drops    = 0;
        exp_err  = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int cyc;
        int w;
        n_cmp     = 0;
        n_err     = 0;
        rdy_rand  = 1'b0;
        hold_mask = '0;
        out_ready = '1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_last   = 1'b0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge clk);
        #1;

        // Single-beat packet to channel 2.
        send_beat(2, 8'hA5, 1'b1, w);
        check("single_valid", 64'(out_valid), 64'b00100);
        check("single_data", 64'(out_data[23:16]), 64'hA5);
        check("single_last", 64'(out_last[2]), 64'd1);
        drain();

        // Four-beat packet: select captured on beat 0, later selects ignored,
        // full throughput with all channels ready.
        send_beat(1, 8'h11, 1'b0, w);
        cyc = w;
        for (int i = 1; i < 4; i++) begin
            send_beat(3, WIDTH'(8'h11 + i), (i == 3), w);
            cyc += w;
        end
        check("locked_throughput", 64'(cyc), 64'd4);
        drain();

        // Channel 0 held while an earlier beat on channel 3 drains.
        hold_mask = 5'b01001;
        @(posedge clk);
        #1;
        send_beat(3, 8'h33, 1'b1, w);
        fork
            send_packet(0, 4, 1'b0, cyc);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("hold_in_ready", 64'(in_ready), 64'd0);
                check("hold_ch0_valid", 64'(out_valid[0]), 64'd1);
                @(posedge clk);
                #1;
                hold_mask = 5'b00001;
                repeat (3) @(posedge clk);
                #1;
                hold_mask = '0;
            end
        join
        drain();

        // Out-of-range select: whole packet discarded and counted once.
        send_packet(6, 3, 1'b0, cyc);
        check("drop_once", 64'(drop_cnt), 64'd1);
        check("drop_no_valid", 64'(out_valid), 64'd0);

        // Counter saturation.
        for (int i = 0; i < 8; i++) begin
            send_packet(int'($urandom_range(5, 7)), int'($urandom_range(1, 3)), 1'b0, cyc);
        end
        @(negedge clk);
        check("drop_saturate", 64'(drop_cnt), 64'(CNT_MAX));
        @(posedge clk);
        #1;

        // Reset in the middle of a routed packet.
        send_beat(3, 8'h5A, 1'b0, w);
        send_beat(1, 8'h5B, 1'b0, w);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_last", 64'(out_last), 64'd0);
        check("midrst_data", 64'(out_data), 64'd0);
        check("midrst_err", 64'(err_sel), 64'd0);
        check("midrst_drop", 64'(drop_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_beat(0, 8'h3C, 1'b1, w);
        check("post_rst_valid", 64'(out_valid), 64'b00001);
        check("post_rst_data", 64'(out_data[7:0]), 64'h3C);
        drain();

        // Randomized traffic with random backpressure and input gaps.
        rdy_rand = 1'b1;
        for (int p = 0; p < 250; p++) begin
            send_packet(int'($urandom_range(0, 7)), int'($urandom_range(1, 4)), 1'b1, cyc);
        end
        drain();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_stream_demux_1xn
`default_nettype wire
